jk_reg_bank: RTL and testbench
==============================

JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of flip-flop bits in the bank (legal range 1..32).
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  1  update enable; 0 holds all state.
REQ-006 Port mode  input  2  operating mode: 00 JK, 01 D, 10 T, 11 COUNT.
REQ-007 Port j  input  WIDTH  per-bit J / D data / T enable; bit 0 doubles as count enable in COUNT.
REQ-008 Port k  input  WIDTH  per-bit K; bit 0 doubles as synchronous clear in COUNT; ignored in D and T.
REQ-009 Port q  output  WIDTH  registered state.
REQ-010 Port qbar  output  WIDTH  bitwise complement of q, always exactly ~q.
REQ-011 Port tc  output  1  combinational terminal count: 1 when mode==COUNT, en==1, j[0]==1, k[0]==0 and q is all ones.
REQ-012 Port chg  output  1  registered pulse: 1 for one cycle after any edge at which q changed value.

Function
REQ-013 With en==0, q SHALL hold and chg SHALL be 0 on the next cycle.
REQ-014 JK mode, per bit: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-015 D mode: q SHALL load j.
REQ-016 T mode: q SHALL load q ^ j.
REQ-017 COUNT mode: k[0]==1 SHALL clear q to 0, with priority over increment; otherwise j[0]==1 SHALL increment q by 1 modulo 2^WIDTH, and j[0]==0 SHALL hold.
REQ-018 COUNT wrap: q all ones with increment SHALL become 0, and tc SHALL be 1 during the cycle before the wrap.
REQ-019 Latency: the new q SHALL be visible one clock after the sampling edge, and chg SHALL assert at the same edge where q changes.
REQ-020 A mode change SHALL take effect at the first edge where it is sampled; no state beyond q and chg is retained.
REQ-021 qbar SHALL never equal q in any bit position, including during and after reset.

Reset
REQ-022 rst_n low SHALL immediately force q=RESET_VAL, qbar=~RESET_VAL and chg=0, regardless of clk.
REQ-023 Reset deassertion mid-operation SHALL resume normal updates at the first rising edge after rst_n is high; no edge is processed while rst_n is low.

Configuration
REQ-024 Macro JK_REG_BANK_COUNT_EN: when defined, mode 11 SHALL behave as COUNT per REQ-017/018.
REQ-025 When JK_REG_BANK_COUNT_EN is undefined, mode 11 SHALL hold q, tc SHALL be tied to 0, and no adder logic SHALL be synthesised.

Structure
REQ-026 Package jk_reg_bank_pkg SHALL hold the 2-bit mode enum (MODE_JK, MODE_D, MODE_T, MODE_COUNT) and the JK truth-table encoding constants.
REQ-027 Per-bit next-state logic for JK/D/T SHALL live in sub-module jk_cell (inputs q, j, k, mode; output next q), instantiated WIDTH times; count/clear muxing and the chg register stay in the top level.

Verification (WIDTH=8, RESET_VAL=0)
REQ-028 Drop rst_n between edges with q=8'h5A -> q=8'h00 and qbar=8'hFF immediately, chg=0.
REQ-029 JK mode, q=8'h0F, j=8'hF0, k=8'hFF -> q=8'hF0 after the edge (low nibble cleared, high nibble toggled), chg=1; then j=k=0 -> q holds, chg=0.
REQ-030 D mode j=8'hA5 -> q=8'hA5; T mode j=8'hFF -> q=8'h5A; en=0 with any j/k -> q stays 8'h5A.
REQ-031 COUNT mode, q=8'hFE, j[0]=1, k[0]=0 -> q=8'hFF with tc=1, next edge q=8'h00 with tc=0.
REQ-032 COUNT mode with j[0]=1 and k[0]=1 at q=8'h33 -> q=8'h00 (clear wins); with the macro undefined, the same stimulus -> q holds at 8'h33 and tc=0.
REQ-033 Every scenario SHALL check qbar==~q on every cycle.

Source files
------------

// File: rtl/jk_reg_bank_pkg.sv
// Shared types for the JK register bank: operating modes and JK truth-table codes.
// Optional COUNT mode is enabled by the JK_REG_BANK_COUNT_EN macro in jk_reg_bank.sv.
package jk_reg_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_D     = 2'b01,
        MODE_T     = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    // JK input pair encoded as {j, k}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_CLEAR  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        r = q;
        case ({j, k})
            JK_HOLD:   r = q;
            JK_CLEAR:  r = 1'b0;
            JK_SET:    r = 1'b1;
            JK_TOGGLE: r = ~q;
            default:   r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit next-state logic for JK, D and T modes; COUNT mode holds here and
// is overridden by the bank's counter path.
module jk_cell
    import jk_reg_bank_pkg::*;
(
    input  logic  q,
    input  logic  j,
    input  logic  k,
    input  mode_e mode,
    output logic  q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_JK: q_next = jk_next(q, j, k);
            MODE_D:  q_next = j;
            MODE_T:  q_next = q ^ j;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK/D/T flip-flops with an optional binary counter mode.
// Define JK_REG_BANK_COUNT_EN to enable COUNT mode (mode 11); otherwise mode 11 holds.
module jk_reg_bank
    import jk_reg_bank_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             chg
);

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] cell_next;
    logic             chg_q;
    logic             chg_d;

    assign mode_s = mode_e'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .q      (q_q[i]),
            .j      (j[i]),
            .k      (k[i]),
            .mode   (mode_s),
            .q_next (cell_next[i])
        );
    end

`ifdef JK_REG_BANK_COUNT_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Clear on k[0] takes priority over increment on j[0]
    always_comb begin
        q_d = q_q;
        if (en) begin
            if (mode_s == MODE_COUNT) begin
                if (k[0]) begin
                    q_d = '0;
                end else if (j[0]) begin
                    q_d = q_q + ONE;
                end else begin
                    q_d = q_q;
                end
            end else begin
                q_d = cell_next;
            end
        end
    end

    assign tc = (mode_s == MODE_COUNT) && en && j[0] && !k[0] && (&q_q);
`else
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = cell_next;
        end
    end

    assign tc = 1'b0;
`endif

    assign chg_d = (q_d != q_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= RESET_VAL;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign chg  = chg_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank (WIDTH=8, RESET_VAL=0): behavioural model
// checked every negedge plus directed literal checks. Honours JK_REG_BANK_COUNT_EN.
module tb_jk_reg_bank;

    localparam int WIDTH = 8;
`ifdef JK_REG_BANK_COUNT_EN
    localparam bit COUNT_ON = 1'b1;
`else
    localparam bit COUNT_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             chg;

    int tests_run;
    int tests_failed;

    logic [WIDTH-1:0] model_q;
    logic             model_chg;

    jk_reg_bank #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .j     (j),
        .k     (k),
        .q     (q),
        .qbar  (qbar),
        .tc    (tc),
        .chg   (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: characteristic equations and plain arithmetic
    always @(posedge clk or negedge rst_n) begin
        logic [WIDTH-1:0] nxt;
        if (!rst_n) begin
            model_q   = 8'h00;
            model_chg = 1'b0;
        end else begin
            nxt = model_q;
            if (en) begin
                if (mode == 2'd0)      nxt = (j & ~model_q) | (~k & model_q);
                else if (mode == 2'd1) nxt = j;
                else if (mode == 2'd2) nxt = model_q ^ j;
                else if (COUNT_ON) begin
                    if (k[0])      nxt = 8'h00;
                    else if (j[0]) nxt = WIDTH'((int'(model_q) + 1) % 256);
                end
            end
            model_chg = (nxt != model_q);
            model_q   = nxt;
        end
    end

    function automatic logic model_tc();
        return COUNT_ON && (mode == 2'd3) && en && j[0] && !k[0] && (model_q == 8'hFF);
    endfunction

    always @(negedge clk) begin
        tests_run++;
        if (q !== model_q || qbar !== ~q || chg !== model_chg || tc !== model_tc()) begin
            tests_failed++;
            $display("[TB] FAIL model_cmp t=%0t q=%h/%h qbar=%h chg=%b/%b tc=%b/%b (actual/required)",
                     $time, q, model_q, qbar, chg, model_chg, tc, model_tc());
        end
    end

    task automatic applyStimulus(input logic e, input logic [1:0] m,
                                 input logic [WIDTH-1:0] jv, input logic [WIDTH-1:0] kv);
        en   = e;
        mode = m;
        j    = jv;
        k    = kv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_q,
                               input logic exp_chg, input logic exp_tc);
        tests_run++;
        if (q !== exp_q || qbar !== ~exp_q || chg !== exp_chg || tc !== exp_tc || model_q !== exp_q) begin
            tests_failed++;
            $display("[TB] FAIL %s q=%h req %h qbar=%h req %h chg=%b req %b tc=%b req %b model_q=%h",
                     name, q, exp_q, qbar, ~exp_q, chg, exp_chg, tc, exp_tc, model_q);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        j     = '0;
        k     = '0;
        #1;
        checkOutput("reset_initial", 8'h00, 1'b0, 1'b0);
        #11 rst_n = 1'b1;

        // Load 5A, then drop reset between edges
        applyStimulus(1'b1, 2'd1, 8'h5A, 8'h00);
        checkOutput("d_load_5a", 8'h5A, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 1'b0, 1'b0);
        // Edge while reset is held must be ignored
        en = 1'b1; mode = 2'd1; j = 8'hFF;
        @(posedge clk);
        #1;
        checkOutput("edge_in_reset", 8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b1;

        applyStimulus(1'b1, 2'd1, 8'h0F, 8'h00);
        checkOutput("resume_d_0f", 8'h0F, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'hF0, 8'hFF);
        checkOutput("jk_clr_tgl", 8'hF0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'h00, 8'h00);
        checkOutput("jk_hold", 8'hF0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'h0A, 8'h00);
        checkOutput("jk_set", 8'hFA, 1'b1, 1'b0);

        applyStimulus(1'b1, 2'd1, 8'hA5, 8'h3C);
        checkOutput("d_a5", 8'hA5, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd2, 8'hFF, 8'h00);
        checkOutput("t_ff", 8'h5A, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd2, 8'h00, 8'hFF);
        checkOutput("t_zero", 8'h5A, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd1, 8'hFF, 8'h33);
        checkOutput("en_off", 8'h5A, 1'b0, 1'b0);

        applyStimulus(1'b1, 2'd1, 8'hFE, 8'h00);
        checkOutput("d_fe", 8'hFE, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h01, 8'h00);
        if (COUNT_ON) checkOutput("cnt_ff", 8'hFF, 1'b1, 1'b1);
        else          checkOutput("cnt_off_hold", 8'hFE, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h01, 8'h00);
        if (COUNT_ON) checkOutput("cnt_wrap", 8'h00, 1'b1, 1'b0);
        else          checkOutput("cnt_off_hold2", 8'hFE, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h00, 8'h00);
        if (COUNT_ON) checkOutput("cnt_idle", 8'h00, 1'b0, 1'b0);
        else          checkOutput("cnt_off_idle", 8'hFE, 1'b0, 1'b0);

        applyStimulus(1'b1, 2'd1, 8'h33, 8'h00);
        checkOutput("d_33", 8'h33, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h01, 8'h01);
        if (COUNT_ON) checkOutput("cnt_clear_wins", 8'h00, 1'b1, 1'b0);
        else          checkOutput("cnt_off_clear", 8'h33, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h01, 8'h00);
        if (COUNT_ON) checkOutput("cnt_inc", 8'h01, 1'b1, 1'b0);
        else          checkOutput("cnt_off_inc", 8'h33, 1'b0, 1'b0);

        applyStimulus(1'b0, 2'd0, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
